// File: rtl/hi_lo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hi_lo_muldiv_unit
//
// Purpose
//   Holds the architectural Hi/Lo register pair and executes the
//   multiply/divide family that targets it: MULT, MULTU, DIV, DIVU, MTHI,
//   MTLO, MADD and MSUB. Multiplies use a radix-2 shift-add engine.
//   Divides use a restoring-subtract engine. Both run for 32 cycles on
//   operand magnitudes. The sign of the result is fixed up in the final step.
//
// Ports
//   Clk        in   1   rising-edge clock for all state
//   Reset      in   1   synchronous, active-high; beats Start and any run
//   Start      in   1   operation request, sampled at the rising edge
//   Op         in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//                       6 MADD, 7 MSUB
//   A          in  32   rs: dividend / multiplicand / move source
//   B          in  32   rt: divisor / multiplier
//   Hi_out     out 32   architectural Hi
//   Lo_out     out 32   architectural Lo
//   Busy       out  1   FSM is in RUN (this is also the state debug view)
//   Done       out  1   one-cycle pulse, Hi_out/Lo_out final
//   DivByZero  out  1   sticky: last accepted DIV/DIVU had B == 0
//
// Handshake
//   Start is a request qualified only by the IDLE state. The unit accepts it
//   on a rising edge where Start=1 and Busy=0. While Busy=1, Start is ignored
//   entirely. Every accepted operation produces exactly one Done pulse. That
//   pulse comes one cycle after acceptance for moves, divide-by-zero and fast
//   multiplies. For iterative operations it comes in the first cycle after
//   Busy drops.
//
// Configuration
//   MULDIV_FAST_MUL_EN  when defined, MULT/MULTU/MADD/MSUB complete at the
//                       accepting edge with a single-cycle product.
//                       Division stays iterative. When undefined (the
//                       default), every multiply uses the 32-cycle engine.
// ---------------------------------------------------------------------------
module hi_lo_muldiv_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi_out,
  output logic [31:0] Lo_out,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q;
  logic [2:0]  op_q;
  logic [31:0] acc_q;      // product high half / partial remainder
  logic [31:0] work_q;     // multiplier being consumed / dividend->quotient
  logic [31:0] mag_q;      // multiplicand or divisor magnitude
  logic        neg_q;      // negate product or quotient at the end
  logic        neg_rem_q;  // negate remainder at the end (sign of A)
  logic [31:0] hi_q, lo_q;
  logic        done_q, dbz_q;

  // ---------------- request decode ----------------
  logic        accept, is_mul, is_div, is_signed, div_zero;
  logic        start_iter, last_step;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign accept    = Start && (state_q == IDLE);
  assign is_mul    = (Op == OP_MULT) || (Op == OP_MULTU) ||
                     (Op == OP_MADD) || (Op == OP_MSUB);
  assign is_div    = (Op == OP_DIV) || (Op == OP_DIVU);
  assign is_signed = (Op == OP_MULT) || (Op == OP_DIV) ||
                     (Op == OP_MADD) || (Op == OP_MSUB);
  assign div_zero  = is_div && (B == 32'd0);

  assign a_neg = is_signed && A[31];
  assign b_neg = is_signed && B[31];
  // The magnitude of 0x80000000 is 0x80000000, read as unsigned. That stays
  // exact because the engines work on unsigned 32-bit magnitudes.
  assign a_mag = a_neg ? (32'd0 - A) : A;
  assign b_mag = b_neg ? (32'd0 - B) : B;

  assign last_step = (state_q == RUN) && (count_q == 5'd31);

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] a_ext, b_ext, fast_prod, fast_hilo;

  // Extend each operand to 64 bits, sign- or zero-extending by opcode.
  // The low 64 bits of the product are then correct for both signednesses.
  assign a_ext     = is_signed ? {{32{A[31]}}, A} : {32'd0, A};
  assign b_ext     = is_signed ? {{32{B[31]}}, B} : {32'd0, B};
  assign fast_prod = a_ext * b_ext;

  always_comb begin
    fast_hilo = fast_prod;
    if (Op == OP_MADD)      fast_hilo = {hi_q, lo_q} + fast_prod;
    else if (Op == OP_MSUB) fast_hilo = {hi_q, lo_q} - fast_prod;
  end

  assign start_iter = accept && is_div && !div_zero;
`else
  assign start_iter = accept && (is_mul || (is_div && !div_zero));
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_iter) state_d = RUN;
      RUN:     if (last_step)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- one iteration step ----------------
  // Shift-add: add the multiplicand when the multiplier LSB is set, then
  // shift the {acc, work} pair right by one. The carry drops into acc[31].
  logic [32:0] mul_sum;
  logic [31:0] mul_hi_nx, mul_lo_nx;

  assign mul_sum   = {1'b0, acc_q} + (work_q[0] ? {1'b0, mag_q} : 33'd0);
  assign mul_hi_nx = mul_sum[32:1];
  assign mul_lo_nx = {mul_sum[0], work_q[31:1]};

  // Restoring division: shift the next dividend bit into the remainder and
  // try to subtract. The remainder stays below the divisor, so the shifted
  // value fits in 33 bits and bit 32 of the difference is the borrow.
  logic [32:0] div_shift, div_diff;
  logic        div_ok;
  logic [31:0] div_hi_nx, div_lo_nx;

  assign div_shift = {acc_q, work_q[31]};
  assign div_diff  = div_shift - {1'b0, mag_q};
  assign div_ok    = !div_diff[32];
  assign div_hi_nx = div_ok ? div_diff[31:0] : div_shift[31:0];
  assign div_lo_nx = {work_q[30:0], div_ok};

  logic op_is_div_q;
  assign op_is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // ---------------- final-step result ----------------
  logic [63:0] prod_mag, prod_signed, final_hilo;
  logic [31:0] quo_signed, rem_signed;

  assign prod_mag    = {mul_hi_nx, mul_lo_nx};
  assign prod_signed = neg_q ? (64'd0 - prod_mag) : prod_mag;
  assign quo_signed  = neg_q ? (32'd0 - div_lo_nx) : div_lo_nx;
  assign rem_signed  = neg_rem_q ? (32'd0 - div_hi_nx) : div_hi_nx;

  // MADD/MSUB can accumulate into the live Hi/Lo here. Hi/Lo cannot change
  // during RUN, so they still hold the values captured at acceptance.
  always_comb begin
    final_hilo = {hi_q, lo_q};
    case (op_q)
      OP_MULT, OP_MULTU: final_hilo = prod_signed;
      OP_MADD:           final_hilo = {hi_q, lo_q} + prod_signed;
      OP_MSUB:           final_hilo = {hi_q, lo_q} - prod_signed;
      OP_DIV, OP_DIVU:   final_hilo = {rem_signed, quo_signed};
      default:           final_hilo = {hi_q, lo_q};
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q   <= 5'd0;
      op_q      <= OP_MULT;
      acc_q     <= 32'd0;
      work_q    <= 32'd0;
      mag_q     <= 32'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        dbz_q <= div_zero;
        if (Op == OP_MTHI) begin
          hi_q   <= A;
          done_q <= 1'b1;
        end else if (Op == OP_MTLO) begin
          lo_q   <= A;
          done_q <= 1'b1;
        end else if (div_zero) begin
          done_q <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
        end else if (is_mul) begin
          {hi_q, lo_q} <= fast_hilo;
          done_q       <= 1'b1;
`endif
        end else begin
          op_q      <= Op;
          count_q   <= 5'd0;
          acc_q     <= 32'd0;
          neg_q     <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          if (is_div) begin
            work_q <= a_mag;
            mag_q  <= b_mag;
          end else begin
            work_q <= b_mag;
            mag_q  <= a_mag;
          end
        end
      end else if (state_q == RUN) begin
        count_q <= count_q + 5'd1;
        acc_q   <= op_is_div_q ? div_hi_nx : mul_hi_nx;
        work_q  <= op_is_div_q ? div_lo_nx : mul_lo_nx;
        if (last_step) begin
          {hi_q, lo_q} <= final_hilo;
          done_q       <= 1'b1;
        end
      end
    end
  end

  assign Hi_out    = hi_q;
  assign Lo_out    = lo_q;
  assign Busy      = (state_q == RUN);
  assign Done      = done_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hi_lo_muldiv_unit
//
// Directed bench for hi_lo_muldiv_unit. Inputs change on the falling edge
// and outputs are sampled on the falling edge. Expected values are worked
// out by hand. Multiply latency follows MULDIV_FAST_MUL_EN, so the same
// bench serves both builds.
// ---------------------------------------------------------------------------
module tb_hi_lo_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  // ---------------- clock / reset / DUT ----------------
  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic [31:0] Hi_out, Lo_out;
  logic        Busy, Done, DivByZero;

  always #5 Clk = ~Clk;

  hi_lo_muldiv_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Hi_out(Hi_out), .Lo_out(Lo_out), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observations of the most recent run_op call.
  int busy_n, done_at, done_n;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    int          lat;
  } vec_t;

  // ---------------- driver ----------------
  // Issue one op, then watch a fixed 40-cycle window. The window bounds the
  // wait. done_at stays -1 when no Done pulse appears.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (Busy === 1'b1) busy_n++;
      if (Done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      @(negedge Clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Op = OP_MULT; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge Clk);
    // Reset must win over a simultaneous request.
    Start = 1'b1; Op = OP_MTHI; A = 32'hDEAD_BEEF;
    repeat (2) @(negedge Clk);
    Reset = 1'b0; Start = 1'b0;
    n_cmp++;
    if ({Hi_out, Lo_out} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_hilo: got %h want %h", {Hi_out, Lo_out}, 64'd0);
    end
    n_cmp++;
    if ({Busy, Done, DivByZero} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000", {Busy, Done, DivByZero});
    end
  endtask

  task automatic test_moves();
    run_op(OP_MTHI, 32'd6, 32'd0);
    n_cmp++;
    if (busy_n !== 0 || done_at !== 0 || done_n !== 1) begin
      n_bad++;
      $display("FAIL mthi_timing: busy=%0d done_at=%0d dones=%0d want 0/0/1", busy_n, done_at, done_n);
    end
    n_cmp++;
    if (Hi_out !== 32'd6) begin
      n_bad++;
      $display("FAIL mthi_value: got %h want %h", Hi_out, 32'd6);
    end
    run_op(OP_MTLO, 32'd5, 32'd0);
    n_cmp++;
    if (busy_n !== 0 || done_at !== 0 || done_n !== 1) begin
      n_bad++;
      $display("FAIL mtlo_timing: busy=%0d done_at=%0d dones=%0d want 0/0/1", busy_n, done_at, done_n);
    end
    n_cmp++;
    if ({Hi_out, Lo_out} !== {32'd6, 32'd5}) begin
      n_bad++;
      $display("FAIL mtlo_value: got %h want %h", {Hi_out, Lo_out}, {32'd6, 32'd5});
    end
  endtask

  task automatic test_mult();
    vec_t v[5];
    v[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA, MUL_LAT};
    v[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,         64'h0000_0002_FFFF_FFFA, MUL_LAT};
    v[2] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, MUL_LAT};
    v[3] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, MUL_LAT};
    v[4] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT};
    for (int k = 0; k < 5; k++) begin
      run_op(v[k].op, v[k].a, v[k].b);
      n_cmp++;
      if (busy_n !== v[k].lat || done_at !== v[k].lat || done_n !== 1) begin
        n_bad++;
        $display("FAIL mult%0d_timing: busy=%0d done_at=%0d dones=%0d want %0d/%0d/1", k, busy_n, done_at, done_n, v[k].lat, v[k].lat);
      end
      n_cmp++;
      if ({Hi_out, Lo_out} !== v[k].hilo) begin
        n_bad++;
        $display("FAIL mult%0d_value: got %h want %h", k, {Hi_out, Lo_out}, v[k].hilo);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[6];
    v[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT};
    v[1] = '{OP_DIVU, 32'd100,       32'd7,         64'h0000_0002_0000_000E, DIV_LAT};
    v[2] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_LAT};
    v[3] = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, DIV_LAT};
    v[4] = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, DIV_LAT};
    v[5] = '{OP_DIVU, 32'd3,         32'd5,         64'h0000_0003_0000_0000, DIV_LAT};
    for (int k = 0; k < 6; k++) begin
      run_op(v[k].op, v[k].a, v[k].b);
      n_cmp++;
      if (busy_n !== v[k].lat || done_at !== v[k].lat || done_n !== 1) begin
        n_bad++;
        $display("FAIL div%0d_timing: busy=%0d done_at=%0d dones=%0d want %0d/%0d/1", k, busy_n, done_at, done_n, v[k].lat, v[k].lat);
      end
      n_cmp++;
      if ({Hi_out, Lo_out} !== v[k].hilo) begin
        n_bad++;
        $display("FAIL div%0d_value: got %h want %h", k, {Hi_out, Lo_out}, v[k].hilo);
      end
    end
  endtask

  // Runs right after test_div, so Hi=3 and Lo=0 on entry.
  task automatic test_div_by_zero();
    run_op(OP_DIVU, 32'd5, 32'd0);
    n_cmp++;
    if (busy_n !== 0 || done_at !== 0 || done_n !== 1) begin
      n_bad++;
      $display("FAIL dbz_timing: busy=%0d done_at=%0d dones=%0d want 0/0/1", busy_n, done_at, done_n);
    end
    n_cmp++;
    if ({DivByZero, Hi_out, Lo_out} !== {1'b1, 32'd3, 32'd0}) begin
      n_bad++;
      $display("FAIL dbz_state: got %h want %h", {DivByZero, Hi_out, Lo_out}, {1'b1, 32'd3, 32'd0});
    end
    run_op(OP_MTLO, 32'd9, 32'd0);
    n_cmp++;
    if ({DivByZero, Lo_out} !== {1'b0, 32'd9}) begin
      n_bad++;
      $display("FAIL dbz_clear_mtlo: got %h want %h", {DivByZero, Lo_out}, {1'b0, 32'd9});
    end
    run_op(OP_DIV, 32'd1, 32'd0);
    n_cmp++;
    if ({DivByZero, Hi_out, Lo_out} !== {1'b1, 32'd3, 32'd9}) begin
      n_bad++;
      $display("FAIL dbz_signed: got %h want %h", {DivByZero, Hi_out, Lo_out}, {1'b1, 32'd3, 32'd9});
    end
    run_op(OP_DIVU, 32'd100, 32'd7);
    n_cmp++;
    if ({DivByZero, Hi_out, Lo_out} !== {1'b0, 32'd2, 32'd14}) begin
      n_bad++;
      $display("FAIL dbz_clear_div: got %h want %h", {DivByZero, Hi_out, Lo_out}, {1'b0, 32'd2, 32'd14});
    end
  endtask

  task automatic test_madd_msub();
    vec_t v[6];
    v[0] = '{OP_MTHI, 32'd0,         32'd0, 64'h0000_0000_0000_000E, 0};
    v[1] = '{OP_MTLO, 32'd10,        32'd0, 64'h0000_0000_0000_000A, 0};
    v[2] = '{OP_MADD, 32'd4,         32'd5, 64'h0000_0000_0000_001E, MUL_LAT};
    v[3] = '{OP_MSUB, 32'd8,         32'd4, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT};
    v[4] = '{OP_MADD, 32'hFFFF_FFFD, 32'd2, 64'hFFFF_FFFF_FFFF_FFF8, MUL_LAT};
    v[5] = '{OP_MADD, 32'd1,         32'd7, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT};
    for (int k = 0; k < 6; k++) begin
      run_op(v[k].op, v[k].a, v[k].b);
      n_cmp++;
      if (busy_n !== v[k].lat || done_at !== v[k].lat || done_n !== 1) begin
        n_bad++;
        $display("FAIL macc%0d_timing: busy=%0d done_at=%0d dones=%0d want %0d/%0d/1", k, busy_n, done_at, done_n, v[k].lat, v[k].lat);
      end
      n_cmp++;
      if ({Hi_out, Lo_out} !== v[k].hilo) begin
        n_bad++;
        $display("FAIL macc%0d_value: got %h want %h", k, {Hi_out, Lo_out}, v[k].hilo);
      end
    end
    // 64-bit wrap: -1 + 1*1 = 0.
    run_op(OP_MADD, 32'd1, 32'd1);
    n_cmp++;
    if ({Hi_out, Lo_out} !== 64'd0) begin
      n_bad++;
      $display("FAIL madd_wrap: got %h want %h", {Hi_out, Lo_out}, 64'd0);
    end
  endtask

  // A divide runs, and an MTHI request is pulsed while Busy is high. The
  // MTHI must be dropped and must not disturb the divide.
  task automatic test_start_ignored();
    @(negedge Clk);
    Start = 1'b1; Op = OP_DIVU; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0; Op = OP_MTHI; A = 32'hDEAD_BEEF;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (Busy === 1'b1) busy_n++;
      if (Done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      Start = (i == 10);
      @(negedge Clk);
    end
    Start = 1'b0;
    n_cmp++;
    if (busy_n !== DIV_LAT || done_at !== DIV_LAT || done_n !== 1) begin
      n_bad++;
      $display("FAIL ignore_timing: busy=%0d done_at=%0d dones=%0d want 32/32/1", busy_n, done_at, done_n);
    end
    n_cmp++;
    if ({Hi_out, Lo_out} !== {32'd2, 32'd14}) begin
      n_bad++;
      $display("FAIL ignore_value: got %h want %h", {Hi_out, Lo_out}, {32'd2, 32'd14});
    end
  endtask

  // Two moves on consecutive cycles: each one gives its own Done pulse.
  task automatic test_back_to_back();
    @(negedge Clk);
    Start = 1'b1; Op = OP_MTHI; A = 32'h0000_AAAA;
    @(negedge Clk);
    Op = OP_MTLO; A = 32'h0000_5555;
    n_cmp++;
    if ({Done, Hi_out} !== {1'b1, 32'h0000_AAAA}) begin
      n_bad++;
      $display("FAIL b2b_first: got %h want %h", {Done, Hi_out}, {1'b1, 32'h0000_AAAA});
    end
    @(negedge Clk);
    Start = 1'b0;
    n_cmp++;
    if ({Done, Hi_out, Lo_out} !== {1'b1, 32'h0000_AAAA, 32'h0000_5555}) begin
      n_bad++;
      $display("FAIL b2b_second: got %h want %h", {Done, Hi_out, Lo_out}, {1'b1, 32'h0000_AAAA, 32'h0000_5555});
    end
    @(negedge Clk);
    n_cmp++;
    if (Done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_done_drop: got %b want 0", Done);
    end
  endtask

  task automatic test_reset_mid_run();
    run_op(OP_MTHI, 32'h11, 32'd0);
    @(negedge Clk);
    Start = 1'b1; Op = OP_DIVU; A = 32'hFFFF_FFFF; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    n_cmp++;
    if (Busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_run_busy: got %b want 1", Busy);
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    n_cmp++;
    if ({Busy, Done, DivByZero, Hi_out, Lo_out} !== 67'd0) begin
      n_bad++;
      $display("FAIL rst_run_state: got %h want %h", {Busy, Done, DivByZero, Hi_out, Lo_out}, 67'd0);
    end
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1 || Busy === 1'b1) done_n++;
      @(negedge Clk);
    end
    n_cmp++;
    if (done_n !== 0 || {Hi_out, Lo_out} !== 64'd0) begin
      n_bad++;
      $display("FAIL rst_run_after: activity=%0d hilo=%h want 0 and %h", done_n, {Hi_out, Lo_out}, 64'd0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_moves();
    test_mult();
    test_div();
    test_div_by_zero();
    test_madd_msub();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hi_lo_muldiv_unit.md
HI_LO_MULDIV_UNIT -- requirements
Module: hi_lo_muldiv_unit

Interface
REQ-001 The block SHALL have one clock, Clk; reset is synchronous and active-high, named Reset.
REQ-002 The block SHALL have no parameters.
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  operation request, sampled at rising edge.
REQ-006 Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-007 A  input  32  first operand (rs); dividend / multiplicand / move source.
REQ-008 B  input  32  second operand (rt); divisor / multiplier.
REQ-009 Hi_out  output  32  architectural Hi register, drives ALU Hi_in.
REQ-010 Lo_out  output  32  architectural Lo register, drives ALU Lo_in.
REQ-011 Busy  output  1  high while an iterative operation is in progress.
REQ-012 Done  output  1  one-cycle pulse: operation retired, Hi_out/Lo_out final.
REQ-013 DivByZero  output  1  sticky flag: last accepted DIV/DIVU had B==0.

Function
REQ-014 States SHALL be IDLE and RUN; Busy SHALL equal (state==RUN).
REQ-015 Start SHALL be accepted only in IDLE; Start during RUN SHALL be ignored with no effect.
REQ-016 On an accepted Start, DivByZero SHALL clear unless set again by that same operation.
REQ-017 MTHI/MTLO: Hi_out (or Lo_out) SHALL load A at the accepting edge; Done high the next cycle; Busy stays 0.
REQ-018 MULT/MULTU/MADD/MSUB/DIV/DIVU with B!=0 SHALL enter RUN with a 5-bit step counter at 0, one shift-add or restoring-subtract step per cycle.
REQ-019 The step at counter 31 SHALL write Hi_out/Lo_out, pulse Done, and return to IDLE: Busy high exactly 32 cycles, Done in the cycle after Busy falls.
REQ-020 Hi_out/Lo_out SHALL hold prior values throughout RUN; partial results live in internal registers only.
REQ-021 MULT/MULTU: {Hi,Lo} = signed/unsigned 64-bit product of A and B.
REQ-022 MADD/MSUB: {Hi,Lo} = {Hi,Lo} +/- signed product, 64-bit, wrap-around on overflow, using {Hi,Lo} captured at acceptance.
REQ-023 DIVU: Lo = A/B, Hi = A%B, unsigned.
REQ-024 DIV: quotient truncates toward zero; remainder takes sign of A; 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0.
REQ-025 DIV/DIVU with B==0: no RUN; Hi/Lo unchanged; DivByZero=1 and Done=1 in the cycle after acceptance.
REQ-026 Signed ops SHALL iterate on magnitudes and apply sign correction in the final step.
REQ-027 Done SHALL never be high for two consecutive cycles from one operation.

Reset
REQ-028 Reset SHALL take priority over Start and any in-progress operation.
REQ-029 On Reset: state IDLE, counter 0, Hi_out=0, Lo_out=0, Busy=0, Done=0, DivByZero=0.
REQ-030 Reset during RUN SHALL abort the operation with no Done pulse and no Hi/Lo update.

Configuration
REQ-031 Macro MULDIV_FAST_MUL_EN defined: MULT/MULTU/MADD/MSUB SHALL complete at the accepting edge (single-cycle product), Done next cycle, Busy never asserted.
REQ-032 MULDIV_FAST_MUL_EN undefined: all multiplies SHALL use the 32-cycle iterative path of REQ-018/019.
REQ-033 Division SHALL be iterative in both configurations.

Verification
REQ-034 Reset, then MTHI A=6, MTLO A=5 -> Hi_out=6, Lo_out=5, Busy never high, one Done after each.
REQ-035 MULT A=0xFFFFFFFE (-2), B=3 -> Busy 32 cycles, Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; MULTU same -> Hi=2, Lo=0xFFFFFFFA.
REQ-036 DIV A=-7, B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU A=100, B=7 -> Lo=14, Hi=2.
REQ-037 DIVU A=5, B=0 -> no Busy, DivByZero=1, Hi/Lo unchanged, Done next cycle; following MTLO clears DivByZero.
REQ-038 Hi=0, Lo=10, MADD A=4, B=5 -> Lo=30; MSUB A=8, B=4 -> Lo=0xFFFFFFFE, Hi=0xFFFFFFFF; Start pulsed mid-RUN ignored.
REQ-039 Reset asserted at cycle 10 of a DIVU -> Busy=0, no Done, Hi=Lo=0 next cycle; rerun both MULDIV_FAST_MUL_EN builds, checking multiply Busy/latency.
